// File: rtl/alu_mp_add_seq.sv
// Multi-precision adder: one 16-bit slice sequenced over WORDS cycles.
// Optional subtract mode via the ALU_MP_ADD_SUB_EN macro.
module alu_mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORDS*16-1:0]  X,
    input  logic [WORDS*16-1:0]  Y,
`ifdef ALU_MP_ADD_SUB_EN
    input  logic                 Sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [WORDS*16-1:0]  Z,
    output logic                 Sign,
    output logic                 Zero,
    output logic                 Carry,
    output logic                 Parity,
    output logic                 Overflow
);

    localparam int W  = WORDS * 16;
    localparam int IW = (WORDS > 2) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  xr;
    logic [W-1:0]  yr;
    logic [IW-1:0] idx;
    logic          cy;
    logic          zacc;
    logic          pacc;
    logic          subr;
    logic          sub_in;

    logic [15:0]   xw;
    logic [15:0]   yw;
    logic [15:0]   s;
    logic          c;
    logic          last;
    logic          accept;

`ifdef ALU_MP_ADD_SUB_EN
    assign sub_in = Sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtract is X + ~Y + 1: invert the B slice, seed the carry with 1.
    always_comb begin
        xw   = xr[idx*16 +: 16];
        yw   = yr[idx*16 +: 16] ^ {16{subr}};
        {c, s} = {1'b0, xw} + {1'b0, yw} + {16'd0, cy};
        last = (idx == IW'(WORDS - 1));
    end

    assign accept = start && (state != RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xr       <= '0;
            yr       <= '0;
            idx      <= '0;
            cy       <= 1'b0;
            zacc     <= 1'b0;
            pacc     <= 1'b0;
            subr     <= 1'b0;
            Z        <= '0;
            Sign     <= 1'b0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Parity   <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            xr   <= X;
            yr   <= Y;
            idx  <= '0;
            cy   <= sub_in;
            zacc <= 1'b1;
            pacc <= 1'b0;
            subr <= sub_in;
        end else if (state == RUN) begin
            Z[idx*16 +: 16] <= s;
            cy   <= c;
            zacc <= zacc & ~|s;
            pacc <= pacc ^ (^s);
            idx  <= idx + 1'b1;
            // Flags reflect the whole word, so they land on the top slice only.
            if (last) begin
                Carry    <= c;
                Sign     <= s[15];
                Zero     <= zacc & ~|s;
                Parity   <= ~(pacc ^ (^s));
                Overflow <= (xw[15] & yw[15] & ~s[15])
                          | (~xw[15] & ~yw[15] & s[15]);
            end
        end
    end

endmodule

// File: tb/tb_alu_mp_add_seq.sv
// Directed bench for alu_mp_add_seq (WORDS=4).
// Subtract vectors are built only with ALU_MP_ADD_SUB_EN.
module tb_alu_mp_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] X;
    logic [63:0] Y;
    logic        busy;
    logic        done;
    logic [63:0] Z;
    logic        Sign;
    logic        Zero;
    logic        Carry;
    logic        Parity;
    logic        Overflow;
`ifdef ALU_MP_ADD_SUB_EN
    logic        Sub;
`endif

    int total = 0;
    int bad   = 0;

    alu_mp_add_seq #(.WORDS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .X       (X),
        .Y       (Y),
`ifdef ALU_MP_ADD_SUB_EN
        .Sub     (Sub),
`endif
        .busy    (busy),
        .done    (done),
        .Z       (Z),
        .Sign    (Sign),
        .Zero    (Zero),
        .Carry   (Carry),
        .Parity  (Parity),
        .Overflow(Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] flags();
        return {Sign, Zero, Carry, Parity, Overflow};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags order: {Sign, Zero, Carry, Parity, Overflow}
    task automatic run_op(input string tag, input logic [63:0] a,
                          input logic [63:0] b, input logic sb,
                          input logic [63:0] ez, input logic [4:0] ef);
        int n;
        X = a;
        Y = b;
`ifdef ALU_MP_ADD_SUB_EN
        Sub = sb;
`else
        if (sb) $display("note: sub vector %s run as add", tag);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        X = '1;
        Y = '1;
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'd4);
        chk({tag, ".busy_dn"}, 64'(busy), 64'd0);
        chk({tag, ".Z"}, Z, ez);
        chk({tag, ".flags"}, 64'(flags()), 64'(ef));
        tick();
        chk({tag, ".pulse"}, 64'(done), 64'd0);
        chk({tag, ".hold"}, Z, ez);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0;
        start = 1'b0;
        X = '0;
        Y = '0;
`ifdef ALU_MP_ADD_SUB_EN
        Sub = 1'b0;
`endif
        tick();
        tick();
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.Z", Z, 64'd0);
        chk("rst.flags", 64'(flags()), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("t1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0,
               64'h0000_0000_0001_0000, 5'b00000);
        run_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0, 5'b01110);
        run_op("t3", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 5'b10001);

        // second start while busy must be ignored
        X = 64'h5;
        Y = 64'h3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        X = 64'h100;
        Y = 64'h100;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("ign.done", 64'(done), 64'd1);
        chk("ign.Z", Z, 64'h8);
        chk("ign.flags", 64'(flags()), 64'd0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dn += int'(done);
        end
        chk("ign.extra", 64'(dn), 64'd0);

        // reset in the middle of RUN
        X = 64'h1111_2222_3333_4444;
        Y = 64'h1111_2222_3333_4444;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.Z", Z, 64'd0);
        chk("abort.flags", 64'(flags()), 64'd0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dn += int'(done);
        end
        chk("abort.nodone", 64'(dn), 64'd0);
        run_op("t5", 64'h2, 64'h2, 1'b0, 64'h4, 5'b00000);

        // back-to-back with start held high
        X = 64'h0001_0002_0003_0004;
        Y = 64'h0010_0020_0030_0040;
        start = 1'b1;
        tick();
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk($sformatf("b2b.done%0d", n), 64'(done),
                64'((n % 5) == 4));
            chk($sformatf("b2b.busy%0d", n), 64'(busy),
                64'((n % 5) != 4));
            if ((n % 5) == 4) begin
                chk($sformatf("b2b.Z%0d", n), Z,
                    64'h0011_0022_0033_0044);
                chk($sformatf("b2b.fl%0d", n), 64'(flags()),
                    64'b00010);
            end
        end
        start = 1'b0;
        dn = 0;
        while ((busy || done) && dn < 20) begin
            tick();
            dn++;
        end
        chk("b2b.idle", 64'(busy | done), 64'd0);

`ifdef ALU_MP_ADD_SUB_EN
        run_op("sub", 64'h5, 64'h7, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 5'b10000);
        run_op("sub0", 64'h5, 64'h7, 1'b0, 64'hC, 5'b00010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
